laplace_window_gen: RTL and testbench

- Streaming window generator directly upstream of the combinational 5-point Laplace filter (laplace9_aprox_1).
- Consumes a raster-order 8-bit grayscale pixel stream, one pixel per handshake, for a COLS x ROWS frame.
- Emits the cross-shaped neighbourhood b/d/e/f/h for every interior pixel.
- Output count is (COLS-2) x (ROWS-2) windows per frame, in raster order, with frame/line markers so the downstream writer needs no counters.

---
 rtl/laplace_window_gen.sv | 148 ++++++++++++++
 tb/tb_laplace_window_gen.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/laplace_window_gen.sv
// laplace_window_gen
//   Streaming cross-window generator feeding a 5-point Laplace filter.
//   Takes a raster-order pixel stream (COLS x ROWS) and, for every interior
//   pixel, emits the neighbourhood b (above), d (left), e (centre),
//   f (right) and h (below), with frame/line markers.
//
// Ports
//   clk, rst_n             clock (rising edge), async active-low reset
//   in_valid/in_ready      input pixel handshake
//   in_pixel               raster pixel, row 0 col 0 first
//   out_valid/out_ready    output window handshake (one-deep register)
//   out_b/d/e/f/h          window taps
//   out_sof/eol/eof        first window of frame / last of row / last of frame
//
// A window is produced on acceptance of pixel (R,C) with R>=2 and C>=2; it is
// centred on (R-1,C-1), so the output lags the input by one row and one pixel.

module laplace_window_gen #(
  parameter int COLS   = 512,
  parameter int ROWS   = 512,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pixel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_b,
  output logic [DATA_W-1:0] out_d,
  output logic [DATA_W-1:0] out_e,
  output logic [DATA_W-1:0] out_f,
  output logic [DATA_W-1:0] out_h,
  output logic              out_sof,
  output logic              out_eol,
  output logic              out_eof
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          accept;
  logic          col_last, row_last;
  logic          win_en;

  // Line buffers: lb1 holds row R-1, lb2 holds row R-2 (no reset, RAM style)
  logic [DATA_W-1:0] lb1_mem [COLS];
  logic [DATA_W-1:0] lb2_mem [COLS];
  logic [DATA_W-1:0] rd1_q, rd2_q;

  // Column taps: top row (R-2,C-1), middle row (R-1,C-1)/(R-1,C-2), current row (R,C-1)
  logic [DATA_W-1:0] top_q, mid1_q, mid2_q, cur_q;

  logic              out_valid_q;
  logic [DATA_W-1:0] b_q, d_q, e_q, f_q, h_q;
  logic              sof_q, eol_q, eof_q;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign col_last = (col_q == CW'(COLS - 1));
  assign row_last = (row_q == RW'(ROWS - 1));
  assign win_en   = (row_q >= RW'(2)) && (col_q >= CW'(2));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Reading at col_d pre-fetches the column the next accepted pixel lands in,
  // so rd1_q/rd2_q are already aligned with (R-1,C)/(R-2,C) at acceptance.
  // The write address (col_q) never equals col_d on an accept since COLS>=3.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1_mem[col_q] <= in_pixel;
      lb2_mem[col_q] <= rd1_q;
    end
    rd1_q <= lb1_mem[col_d];
    rd2_q <= lb2_mem[col_d];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q  <= '0;
      row_q  <= '0;
      top_q  <= '0;
      mid1_q <= '0;
      mid2_q <= '0;
      cur_q  <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      if (accept) begin
        top_q  <= rd2_q;
        mid2_q <= mid1_q;
        mid1_q <= rd1_q;
        cur_q  <= in_pixel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      b_q         <= '0;
      d_q         <= '0;
      e_q         <= '0;
      f_q         <= '0;
      h_q         <= '0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      eof_q       <= 1'b0;
    end else if (accept && win_en) begin
      out_valid_q <= 1'b1;
      b_q         <= top_q;
      d_q         <= mid2_q;
      e_q         <= mid1_q;
      f_q         <= rd1_q;
      h_q         <= cur_q;
      sof_q       <= (row_q == RW'(2)) && (col_q == CW'(2));
      eol_q       <= col_last;
      eof_q       <= row_last && col_last;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_b     = b_q;
  assign out_d     = d_q;
  assign out_e     = e_q;
  assign out_f     = f_q;
  assign out_h     = h_q;
  assign out_sof   = sof_q;
  assign out_eol   = eol_q;
  assign out_eof   = eof_q;

endmodule

// File: tb/tb_laplace_window_gen.sv
module tb_laplace_window_gen;

  localparam int COLS = 8;
  localparam int ROWS = 6;
  localparam int DW   = 8;
  localparam int NWIN = (COLS - 2) * (ROWS - 2);

  typedef logic [5*DW+2:0] win_t; // {sof,eol,eof,b,d,e,f,h}

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_pixel = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_b, out_d, out_e, out_f, out_h;
  logic          out_sof, out_eol, out_eof;

  laplace_window_gen #(.COLS(COLS), .ROWS(ROWS), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_b(out_b), .out_d(out_d), .out_e(out_e), .out_f(out_f), .out_h(out_h),
    .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] pix_q[$];
  win_t          exp_q[$];

  int   acc_cnt, win_cnt, eol_cnt, acc_at_first;
  bit   have_first;
  win_t first_w, last_w;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic win_t cur_win();
    return {out_sof, out_eol, out_eof, out_b, out_d, out_e, out_f, out_h};
  endfunction

  // Reference: whole image first, then every interior centre (r,c) in raster order
  task automatic load_frame(input int mode);
    logic [DW-1:0] img [ROWS][COLS];
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        img[r][c] = (mode == 0) ? DW'((3 * r + c) & 255) : DW'($urandom);
        pix_q.push_back(img[r][c]);
      end
    for (int r = 1; r < ROWS - 1; r++)
      for (int c = 1; c < COLS - 1; c++)
        exp_q.push_back({(r == 1 && c == 1), (c == COLS - 2), (r == ROWS - 2 && c == COLS - 2),
                         img[r-1][c], img[r][c-1], img[r][c], img[r][c+1], img[r+1][c]});
  endtask

  // Called and returns at a negedge. max_pix<0 runs until all queues drain.
  task automatic run(input int vpct, input int rpct, input int max_pix,
                     input int stall_at, input int budget);
    int   cyc = 0;
    int   stall_left = 5;
    bit   hold_prev = 0;
    win_t prev_w = '0;
    win_t w;
    acc_cnt = 0; win_cnt = 0; eol_cnt = 0; have_first = 0; acc_at_first = -1;
    while (cyc < budget) begin
      if (pix_q.size() == 0 && exp_q.size() == 0 && !out_valid) break;
      if (max_pix >= 0 && acc_cnt >= max_pix) break;
      @(posedge clk); #1;
      in_valid  = (pix_q.size() > 0) && ($urandom_range(99) < vpct);
      in_pixel  = (pix_q.size() > 0) ? pix_q[0] : '0;
      out_ready = ($urandom_range(99) < rpct);
      if (stall_at >= 0 && acc_cnt >= stall_at && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end
      @(negedge clk);
      cyc++;
      w = cur_win();
      if (hold_prev) begin
        chk("hold_win", w, prev_w);
        chk("hold_valid", out_valid, 1);
      end
      if (out_valid && !out_ready) chk("bp_in_ready", in_ready, 0);
      if (out_valid && out_ready) begin
        win_cnt++;
        if (!have_first) begin
          have_first = 1; first_w = w; acc_at_first = acc_cnt;
        end
        last_w = w;
        if (out_eol) eol_cnt++;
        if (exp_q.size() == 0) chk("extra_win", w, 0);
        else chk("window", w, exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        void'(pix_q.pop_front());
        acc_cnt++;
      end
      hold_prev = out_valid && !out_ready;
      prev_w    = w;
    end
    in_valid = 1'b0;
    if (cyc >= budget) chk("timeout", 1, 0);
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_win", cur_win(), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_valid", out_valid, 0);
    chk("idle_ready", in_ready, 1);

    // pattern frame, full throughput
    load_frame(0);
    run(100, 100, -1, -1, 2000);
    chk("cnt_full", win_cnt, NWIN);
    chk("first_win", first_w, {3'b100, 8'd1, 8'd3, 8'd4, 8'd5, 8'd7});
    chk("first_lat", acc_at_first, 2 * COLS + 3);
    chk("eol_cnt", eol_cnt, ROWS - 2);
    chk("last_eof", last_w[5*DW], 1);
    chk("last_e", last_w[3*DW-1:2*DW], (3 * (ROWS - 2) + COLS - 2) & 255);

    // deterministic 5-cycle stall mid-row
    load_frame(0);
    run(100, 100, -1, 3 * COLS + 3, 2000);
    chk("cnt_stall", win_cnt, NWIN);

    // in_valid throttled ~30%
    load_frame(0);
    run(70, 100, -1, -1, 4000);
    chk("cnt_thr", win_cnt, NWIN);

    // random data, random throttling on both sides, two frames back to back
    load_frame(1);
    load_frame(1);
    run(70, 60, -1, -1, 8000);
    chk("cnt_b2b", win_cnt, 2 * NWIN);

    // reset mid-frame
    load_frame(1);
    run(100, 100, 2 * COLS + 5, -1, 2000);
    chk("pre_rst_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1 chk("rst_async_valid", out_valid, 0);
    pix_q.delete();
    exp_q.delete();
    @(negedge clk);
    chk("rst_hold_valid", out_valid, 0);
    chk("rst_hold_win", cur_win(), 0);
    rst_n = 1'b1;
    @(negedge clk);
    load_frame(0);
    run(100, 100, -1, -1, 2000);
    chk("cnt_after_rst", win_cnt, NWIN);
    chk("first_after_rst", first_w, {3'b100, 8'd1, 8'd3, 8'd4, 8'd5, 8'd7});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
